// File: rtl/multdiv_issue_pkg.sv
// Shared encodings for the mul/div issue controller: FSM state codes,
// writeback exception codes and the status register index.
package multdiv_issue_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_START = 2'd1;
   localparam state_t ST_BUSY  = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   localparam logic [4:0]  RSTATUS_REG = 5'd30;
   localparam logic [31:0] EXC_MUL     = 32'd4;
   localparam logic [31:0] EXC_DIV     = 32'd5;
   localparam logic [31:0] EXC_TIMEOUT = 32'd6;

   localparam int MAX_CYCLES_DEFAULT = 40;

   // Exception code written to rstatus when the unit flags an error.
   function automatic logic [31:0] excCode(input logic isDiv);
      return isDiv ? EXC_DIV : EXC_MUL;
   endfunction

endpackage

// File: rtl/multdiv_issue_timeout_counter.sv
// Counts BUSY cycles for the issue controller; o_lastCycle marks the final
// cycle the controller may still wait for a result before timing out.
module issue_timeout_counter
   import multdiv_issue_pkg::*;
#(
   parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_lastCycle
);

   localparam int W = $clog2(MAX_CYCLES + 1);

   logic [W-1:0] r_count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != W'(MAX_CYCLES))) begin
         r_count <= r_count + W'(1);
      end
   end

   // Flag is high during the MAX_CYCLES-th enabled cycle.
   assign o_lastCycle = (r_count == W'(MAX_CYCLES - 1));

endmodule

// File: rtl/multdiv_issue.sv
// Issue/writeback controller in front of the multiply/divide unit: captures
// one op, pulses its start, stalls until a result or timeout, writes back once.
module multdiv_issue
   import multdiv_issue_pkg::*;
#(
   parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_mul,
   input  logic        req_div,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [4:0]  req_rd,
   input  logic        flush,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic [31:0] data_operandA,
   output logic [31:0] data_operandB,
   input  logic [31:0] data_result,
   input  logic        data_exception,
   input  logic        data_resultRDY,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   state_t      r_state;
   state_t      w_nextState;
   logic        r_ctrlMult;
   logic        r_ctrlDiv;
   logic [31:0] r_operandA;
   logic [31:0] r_operandB;
   logic [4:0]  r_rd;
   logic        r_opIsDiv;
   logic        r_wbValid;
   logic [4:0]  r_wbRd;
   logic [31:0] r_wbData;
   logic        w_accept;
   logic        w_lastCycle;
   logic        w_busyEnd;

   assign w_accept  = (r_state == ST_IDLE) && (req_mul || req_div) && !flush;
   assign w_busyEnd = (r_state == ST_BUSY) && !flush && (data_resultRDY || w_lastCycle);

   issue_timeout_counter #(
      .MAX_CYCLES (MAX_CYCLES)
   ) u_timeout (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_clear     (r_state == ST_START),
      .i_enable    (r_state == ST_BUSY),
      .o_lastCycle (w_lastCycle)
   );

   // Flush aborts from any non-idle state and beats a same-cycle RDY.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_nextState = ST_START;
         ST_START: w_nextState = flush ? ST_IDLE : ST_BUSY;
         ST_BUSY: begin
            if (flush)          w_nextState = ST_IDLE;
            else if (w_busyEnd) w_nextState = ST_DONE;
         end
         ST_DONE:  w_nextState = ST_IDLE;
         default:  w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_ctrlMult <= 1'b0;
         r_ctrlDiv  <= 1'b0;
         r_operandA <= '0;
         r_operandB <= '0;
         r_rd       <= '0;
         r_opIsDiv  <= 1'b0;
         r_wbValid  <= 1'b0;
         r_wbRd     <= '0;
         r_wbData   <= '0;
      end else begin
         r_state    <= w_nextState;
         r_ctrlMult <= w_accept && req_mul;
         r_ctrlDiv  <= w_accept && !req_mul;
         r_wbValid  <= 1'b0;
         if (w_accept) begin
            r_operandA <= req_a;
            r_operandB <= req_b;
            r_rd       <= req_rd;
            r_opIsDiv  <= !req_mul;
         end
         // A clean result to r0 still latches but never raises the strobe.
         if (w_busyEnd) begin
            if (!data_resultRDY) begin
               r_wbData  <= EXC_TIMEOUT;
               r_wbRd    <= RSTATUS_REG;
               r_wbValid <= 1'b1;
            end else if (data_exception) begin
               r_wbData  <= excCode(r_opIsDiv);
               r_wbRd    <= RSTATUS_REG;
               r_wbValid <= 1'b1;
            end else begin
               r_wbData  <= data_result;
               r_wbRd    <= r_rd;
               r_wbValid <= (r_rd != 5'd0);
            end
         end
      end
   end

   assign stall = w_accept || (r_state == ST_START) || (r_state == ST_BUSY);

   assign ctrl_MULT     = r_ctrlMult;
   assign ctrl_DIV      = r_ctrlDiv;
   assign data_operandA = r_operandA;
   assign data_operandB = r_operandB;
   assign wb_valid      = r_wbValid;
   assign wb_rd         = r_wbRd;
   assign wb_data       = r_wbData;

endmodule

// File: tb/tb_multdiv_issue.sv
// Self-checking bench for multdiv_issue: the bench plays the multiply/divide
// unit and predicts each writeback from the arithmetic and the issue rules.
module tb_multdiv_issue;

   localparam int          REF_MAX_CYCLES = 40;
   localparam logic [4:0]  REF_RSTATUS    = 5'd30;
   localparam logic [31:0] REF_EXC_MUL    = 32'd4;
   localparam logic [31:0] REF_EXC_DIV    = 32'd5;
   localparam logic [31:0] REF_EXC_TIME   = 32'd6;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_mul;
   logic        req_div;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_rd;
   logic        flush;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   multdiv_issue dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .req_mul        (req_mul),
      .req_div        (req_div),
      .req_a          (req_a),
      .req_b          (req_b),
      .req_rd         (req_rd),
      .flush          (flush),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .stall          (stall),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Arithmetic the multiply/divide unit would produce, with its error flag.
   task automatic multdivModel(input bit isDiv, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output logic exc);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint r;
      if (!isDiv) begin
         r   = sa * sb;
         exc = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end else if (sb == 0) begin
         r   = 0;
         exc = 1'b1;
      end else begin
         r   = sa / sb;
         exc = 1'b0;
      end
      res = r[31:0];
   endtask

   function automatic wb_t refWriteback(input bit isDiv, input logic [4:0] rd, input bit timedOut,
                                        input logic exc, input logic [31:0] res);
      wb_t w;
      if (timedOut) begin
         w.valid = 1'b1; w.rd = REF_RSTATUS; w.data = REF_EXC_TIME;
      end else if (exc) begin
         w.valid = 1'b1; w.rd = REF_RSTATUS; w.data = isDiv ? REF_EXC_DIV : REF_EXC_MUL;
      end else begin
         w.valid = (rd != 5'd0); w.rd = rd; w.data = res;
      end
      return w;
   endfunction

   task automatic idleCycle();
      req_mul = 1'b0; req_div = 1'b0; flush = 1'b0; data_resultRDY = 1'b0;
      @(negedge clock);
      checkOutput("idleStall", 32'(stall), 32'd0);
      checkOutput("idleWbValid", 32'(wb_valid), 32'd0);
      @(posedge clock); #1;
   endtask

   // One op from IDLE: rdyAt is the BUSY cycle carrying RDY (beyond the
   // timeout budget means never), flushAt the BUSY cycle carrying flush.
   task automatic applyStimulus(input bit doMul, input bit doDiv, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd,
                                input int rdyAt, input int flushAt);
      bit          isDiv = !doMul;
      logic [31:0] res;
      logic        exc;
      bit          timedOut = 1'b0;
      bit          flushed  = 1'b0;
      wb_t         expWb;
      multdivModel(isDiv, a, b, res, exc);

      req_mul = doMul; req_div = doDiv; req_a = a; req_b = b; req_rd = rd;
      flush = 1'b0; data_resultRDY = 1'b0; data_exception = 1'b0;
      @(negedge clock);
      checkOutput("issueStall", 32'(stall), 32'd1);
      checkOutput("issueWbValid", 32'(wb_valid), 32'd0);
      @(posedge clock); #1;

      req_a = ~a; req_b = ~b;
      data_resultRDY = 1'b1; data_result = 32'hDEAD_BEEF; data_exception = 1'b1;
      @(negedge clock);
      checkOutput("startMult", 32'(ctrl_MULT), 32'(!isDiv));
      checkOutput("startDiv", 32'(ctrl_DIV), 32'(isDiv));
      checkOutput("startOpA", data_operandA, a);
      checkOutput("startOpB", data_operandB, b);
      checkOutput("startStall", 32'(stall), 32'd1);
      @(posedge clock); #1;

      for (int k = 1; k <= REF_MAX_CYCLES; k++) begin
         data_resultRDY = (k == rdyAt);
         data_result    = (k == rdyAt) ? res : $urandom;
         data_exception = (k == rdyAt) ? exc : 1'b0;
         flush          = (k == flushAt);
         @(negedge clock);
         checkOutput("busyStall", 32'(stall), 32'd1);
         checkOutput("busyCtrl", 32'(ctrl_MULT | ctrl_DIV), 32'd0);
         checkOutput("busyWbValid", 32'(wb_valid), 32'd0);
         checkOutput("busyOpA", data_operandA, a);
         @(posedge clock); #1;
         if (k == flushAt) begin flushed = 1'b1; break; end
         if (k == rdyAt) break;
         if (k == REF_MAX_CYCLES) timedOut = 1'b1;
      end
      data_resultRDY = 1'b0; flush = 1'b0; data_exception = 1'b0;

      if (flushed) begin
         req_mul = 1'b0; req_div = 1'b0;
         for (int j = 0; j < 3; j++) begin
            data_resultRDY = (j == 0);
            data_result    = res;
            @(negedge clock);
            checkOutput("flushStall", 32'(stall), 32'd0);
            checkOutput("flushWbValid", 32'(wb_valid), 32'd0);
            @(posedge clock); #1;
         end
         data_resultRDY = 1'b0;
      end else begin
         expWb = refWriteback(isDiv, rd, timedOut, exc, res);
         @(negedge clock);
         checkOutput("doneWbValid", 32'(wb_valid), 32'(expWb.valid));
         checkOutput("doneWbRd", 32'(wb_rd), 32'(expWb.rd));
         checkOutput("doneWbData", wb_data, expWb.data);
         checkOutput("doneStall", 32'(stall), 32'd0);
         checkOutput("doneCtrl", 32'(ctrl_MULT | ctrl_DIV), 32'd0);
         @(posedge clock); #1;
         req_mul = 1'b0; req_div = 1'b0;
      end
   endtask

   // Asynchronous reset dropped between edges while an op is in BUSY.
   task automatic applyResetMidBusy();
      req_mul = 1'b1; req_div = 1'b0; req_a = 32'd11; req_b = 32'd13; req_rd = 5'd9;
      flush = 1'b0; data_resultRDY = 1'b0;
      repeat (7) @(posedge clock);
      #3;
      reset_n = 1'b0; req_mul = 1'b0;
      #1;
      checkOutput("rstStall", 32'(stall), 32'd0);
      checkOutput("rstCtrl", 32'(ctrl_MULT | ctrl_DIV), 32'd0);
      checkOutput("rstWbValid", 32'(wb_valid), 32'd0);
      checkOutput("rstOpA", data_operandA, 32'd0);
      checkOutput("rstOpB", data_operandB, 32'd0);
      checkOutput("rstWbRd", 32'(wb_rd), 32'd0);
      checkOutput("rstWbData", wb_data, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      idleCycle();
   endtask

   initial begin
      reset_n = 1'b0; req_mul = 1'b0; req_div = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
      flush = 1'b0; data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("resetStall", 32'(stall), 32'd0);
      checkOutput("resetCtrl", 32'(ctrl_MULT | ctrl_DIV), 32'd0);
      checkOutput("resetWbValid", 32'(wb_valid), 32'd0);
      checkOutput("resetOpA", data_operandA, 32'd0);
      checkOutput("resetWbRd", 32'(wb_rd), 32'd0);
      checkOutput("resetWbData", wb_data, 32'd0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 33, 0);
      applyStimulus(1'b0, 1'b1, 32'd100, 32'd0, 5'd8, 12, 0);
      applyStimulus(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 5'd3, 1, 0);
      applyStimulus(1'b1, 1'b0, 32'd9, 32'd9, 5'd0, 5, 0);
      idleCycle();
      applyStimulus(1'b1, 1'b0, 32'd5, 32'd6, 5'd10, 25, 10);
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFCE, 32'd7, 5'd12, 3, 0);
      applyStimulus(1'b1, 1'b1, 32'd3, 32'd4, 5'd6, 0, 0);
      applyStimulus(1'b1, 1'b0, 32'd2, 32'd3, 5'd7, 40, 0);
      applyResetMidBusy();
      applyStimulus(1'b0, 1'b1, 32'd81, 32'd9, 5'd4, 2, 0);

      for (int n = 0; n < 12; n++) begin
         bit          m;
         bit          d;
         logic [31:0] a;
         logic [31:0] b;
         m = 1'($urandom_range(0, 1));
         d = m ? 1'($urandom_range(0, 1)) : 1'b1;
         a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1000)) - 32'd500 : $urandom;
         b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(0, 2000)) - 32'd1000;
         applyStimulus(m, d, a, b, 5'($urandom_range(0, 31)), $urandom_range(1, 45),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0);
      end
      idleCycle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
